// File: rtl/umem_pkg.sv
// Shared constants and FSM state type for the unified memory.
package umem_pkg;

  localparam int          DATA_W_DEF      = 32;
  localparam int          ADDR_W_DEF      = 32;
  localparam int          DEPTH_DEF       = 1024;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'h00400000;
  localparam int          WAIT_STATES_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } umem_state_e;

endpackage

// File: rtl/umem_array.sv
// Word storage with synchronous byte-enabled write and combinational read; not reset.
module umem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/unified_mem.sv
// Single-port request/response memory with configurable wait states.
// Define UMEM_ERR_EN to flag out-of-range or misaligned accesses instead of wrapping.
module unified_mem
  import umem_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DEPTH       = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DEF),
  parameter int                WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output umem_state_e         dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; once raised, rsp_valid
  // and its payload hold until that transfer.

  localparam int                BYTES      = DATA_W / 8;
  localparam int                OFF_W      = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic              NO_WAIT    = (WAIT_STATES == 0);
  localparam logic [3:0]        WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  umem_state_e         state;
  logic [3:0]          wait_cnt;
  logic                lat_we;
  logic [BYTES-1:0]    lat_be;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                accept, enter_resp, cur_we, cur_err, mem_we;
  logic [BYTES-1:0]    cur_be;
  logic [ADDR_W-1:0]   cur_addr, offset, word_off;
  logic [DATA_W-1:0]   cur_wdata, mem_rdata;
  logic [IDX_W-1:0]    cur_idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // A zero-wait access commits on its own accept edge, before the latches load.
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_be    = (state == IDLE) ? req_be    : lat_be;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign offset   = cur_addr - BASE_ADDR;
  assign word_off = (offset >> OFF_W) % ADDR_W'(DEPTH);
  assign cur_idx  = word_off[IDX_W-1:0];

`ifdef UMEM_ERR_EN
  // Addresses below the base wrap to large offsets, so one compare covers both ends.
  assign cur_err = (offset >= SPAN) || ((offset & ALIGN_MASK) != '0);
`else
  assign cur_err = 1'b0;
`endif

  assign enter_resp = ((state == IDLE) && accept && NO_WAIT) ||
                      ((state == WAIT) && (wait_cnt == 4'd0));
  assign mem_we     = enter_resp && cur_we && !cur_err && rst;

  umem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (cur_be),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_we || cur_err) ? '0 : mem_rdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_be    <= req_be;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
